// File: rtl/fx_requant_sat_if.sv
// Streaming handshake bundle for fx_requant_sat: sample in, requantized sample out,
// plus the saturation status and clear.
interface fx_requant_sat_if #(
   parameter int IW = 16,
   parameter int OW = 12
);
   logic [IW-1:0] i_data;
   logic          i_valid;
   logic          o_ready;
   logic [OW-1:0] o_data;
   logic          o_valid;
   logic          i_ready;
   logic          o_sat;
   logic          o_sat_sticky;
   logic [7:0]    o_sat_cnt;
   logic          i_clr;

   modport slave (
      input  i_data, i_valid, i_ready, i_clr,
      output o_ready, o_data, o_valid, o_sat, o_sat_sticky, o_sat_cnt
   );

   modport master (
      output i_data, i_valid, i_ready, i_clr,
      input  o_ready, o_data, o_valid, o_sat, o_sat_sticky, o_sat_cnt
   );
endinterface

// File: rtl/fx_requant_sat.sv
// Two-stage requantizer: round-half-up drop of FRAC_DROP LSBs, then saturate to OW bits,
// with a stalling valid/ready pipeline and a saturation event counter.
module fx_requant_sat #(
   parameter int IW        = 16,
   parameter int OW        = 12,
   parameter int FRAC_DROP = 2
) (
   input logic           clk,
   input logic           rst_n,
   fx_requant_sat_if.slave bus
);

   localparam int RW = IW + 1;
   localparam logic signed [RW-1:0] HALF  = RW'(1 << (FRAC_DROP - 1));
   localparam logic signed [RW-1:0] MAX_R = RW'((1 << (OW - 1)) - 1);
   localparam logic signed [RW-1:0] MIN_R = RW'(-(1 << (OW - 1)));

   logic signed [RW-1:0] ext_w;
   logic signed [RW-1:0] sum_w;
   logic signed [RW-1:0] r_d;
   logic signed [RW-1:0] r_q;
   logic                 v1_q;

   logic [OW-1:0]        data_d;
   logic [OW-1:0]        data_q;
   logic                 sat_d;
   logic                 sat_q;
   logic                 v2_q;

   logic [7:0]           cnt_d;
   logic [7:0]           cnt_q;
   logic                 sticky_d;
   logic                 sticky_q;

   logic                 en;
   logic                 out_xfer;

   // The whole pipeline advances together; a stalled output freezes S1 as well.
   assign en       = !v2_q || bus.i_ready;
   assign out_xfer = v2_q && bus.i_ready;

   // One extra bit of headroom keeps the rounding add from wrapping at the positive limit.
   assign ext_w = RW'(signed'(bus.i_data));
   assign sum_w = ext_w + HALF;
   assign r_d   = sum_w >>> FRAC_DROP;

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      data_d = r_q[OW-1:0];
      sat_d  = 1'b0;
      if (r_q > MAX_R) begin
         data_d = MAX_R[OW-1:0];
         sat_d  = 1'b1;
      end else if (r_q < MIN_R) begin
         data_d = MIN_R[OW-1:0];
         sat_d  = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all stages sample pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         r_q    <= '0;
         v2_q   <= 1'b0;
         data_q <= '0;
         sat_q  <= 1'b0;
      end else if (en) begin
         v1_q   <= bus.i_valid;
         r_q    <= r_d;
         v2_q   <= v1_q;
         data_q <= data_d;
         sat_q  <= sat_d;
      end
   end

   // Clear takes priority over a clipped transfer in the same cycle.
   always_comb begin
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      if (bus.i_clr) begin
         cnt_d    = '0;
         sticky_d = 1'b0;
      end else if (out_xfer && sat_q) begin
         sticky_d = 1'b1;
         if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
      end
   end

   assign bus.o_ready      = en;
   assign bus.o_valid      = v2_q;
   assign bus.o_data       = data_q;
   assign bus.o_sat        = sat_q;
   assign bus.o_sat_cnt    = cnt_q;
   assign bus.o_sat_sticky = sticky_q;

endmodule

// File: tb/tb_fx_requant_sat.sv
// Scoreboard bench for fx_requant_sat: directed rounding/saturation vectors, latency,
// random backpressure, counter saturation/clear and mid-stream reset.
module tb_fx_requant_sat;

   localparam int IW = 16;
   localparam int OW = 12;
   localparam int FD = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic rand_ready = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   logic [12:0] q[$];

   int          exp_cnt;
   logic        exp_sticky;
   logic        stalled_prev;
   logic [12:0] held;

   fx_requant_sat_if #(.IW(IW), .OW(OW)) bus ();

   fx_requant_sat #(.IW(IW), .OW(OW), .FRAC_DROP(FD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: {sat, data} for one input sample.
   function automatic logic [12:0] model(input logic [IW-1:0] d);
      int v;
      int r;
      logic [31:0] rv;
      v  = int'(signed'(d));
      r  = (v + (1 << (FD - 1))) >>> FD;
      rv = r;
      if (r > 2047)       return {1'b1, 12'h7FF};
      else if (r < -2048) return {1'b1, 12'h800};
      else                return {1'b0, rv[11:0]};
   endfunction

   initial begin
      bus.i_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: pops the scoreboard on each output transfer and tracks the counter model.
   initial begin
      logic [12:0] e;
      exp_cnt      = 0;
      exp_sticky   = 1'b0;
      stalled_prev = 1'b0;
      held         = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_cnt      = 0;
            exp_sticky   = 1'b0;
            stalled_prev = 1'b0;
         end else begin
            check("sat_cnt", 32'(bus.o_sat_cnt), 32'(exp_cnt));
            check("sat_sticky", 32'(bus.o_sat_sticky), 32'(exp_sticky));
            if (bus.o_valid && !bus.i_ready) check("o_ready_stall", 32'(bus.o_ready), 32'd0);
            if (stalled_prev) check("stall_stable", 32'({bus.o_sat, bus.o_data}), 32'(held));
            e = '0;
            if (bus.o_valid && bus.i_ready) begin
               if (q.size() == 0) begin
                  check("spurious_output", 32'd1, 32'd0);
               end else begin
                  e = q.pop_front();
                  check("out_data", 32'({bus.o_sat, bus.o_data}), 32'(e));
               end
            end
            if (bus.i_clr) begin
               exp_cnt    = 0;
               exp_sticky = 1'b0;
            end else if (bus.o_valid && bus.i_ready && e[12]) begin
               exp_sticky = 1'b1;
               if (exp_cnt < 255) exp_cnt++;
            end
            stalled_prev = bus.o_valid && !bus.i_ready;
            held         = {bus.o_sat, bus.o_data};
         end
      end
   end

   task automatic send(input logic [IW-1:0] d, input logic [12:0] exp);
      int k;
      bus.i_data  = d;
      bus.i_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!bus.o_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) check("send_timeout", 32'd0, 32'd1);
      else          q.push_back(exp);
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (q.size() != 0 && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (k >= 500) check("drain_timeout", 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   logic [IW-1:0] dir_in  [7] = '{16'h0005, 16'hFFFB, 16'h1FFD, 16'h1FFE, 16'h7FFF, 16'h8000, 16'hE000};
   logic [12:0]   dir_exp [7] = '{13'h0001, 13'h0FFF, 13'h07FF, 13'h17FF, 13'h17FF, 13'h1800, 13'h0800};

   initial begin
      rst_n       = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      bus.i_clr   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_o_valid", 32'(bus.o_valid), 32'd0);
      check("rst_o_ready", 32'(bus.o_ready), 32'd1);
      check("rst_sat_cnt", 32'(bus.o_sat_cnt), 32'd0);
      check("rst_sticky", 32'(bus.o_sat_sticky), 32'd0);

      // Directed rounding and saturation edges, back to back.
      for (int i = 0; i < 7; i++) send(dir_in[i], dir_exp[i]);
      drain();

      // Single-sample latency.
      bus.i_data  = 16'h0123;
      bus.i_valid = 1'b1;
      @(negedge clk);
      check("lat_t", 32'(bus.o_valid), 32'd0);
      check("lat_ready", 32'(bus.o_ready), 32'd1);
      q.push_back(model(16'h0123));
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      @(negedge clk);
      check("lat_t1", 32'(bus.o_valid), 32'd0);
      @(negedge clk);
      check("lat_t2", 32'(bus.o_valid), 32'd1);
      @(negedge clk);
      check("lat_t3", 32'(bus.o_valid), 32'd0);
      @(posedge clk);
      #1;

      // Ramp and random samples under random backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 10; i++) send(IW'(16'h1F80 + i * 16'h0011), model(IW'(16'h1F80 + i * 16'h0011)));
      for (int i = 0; i < 30; i++) begin
         logic [IW-1:0] d;
         d = IW'($urandom);
         send(d, model(d));
      end
      rand_ready = 1'b0;
      drain();

      // Counter saturation and clear-wins.
      for (int i = 0; i < 300; i++) send(16'h7FFF, 13'h17FF);
      drain();
      check("cnt_255", 32'(bus.o_sat_cnt), 32'd255);
      check("sticky_set", 32'(bus.o_sat_sticky), 32'd1);
      send(16'h8000, 13'h1800);
      @(posedge clk);
      #1;
      check("clr_pending_valid", 32'({bus.o_valid, bus.o_sat}), 32'd3);
      bus.i_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.i_clr = 1'b0;
      check("clr_cnt", 32'(bus.o_sat_cnt), 32'd0);
      check("clr_sticky", 32'(bus.o_sat_sticky), 32'd0);
      drain();

      // Mid-stream reset with two samples in flight.
      send(16'h7FFF, 13'h17FF);
      send(16'h0040, model(16'h0040));
      rst_n = 1'b0;
      q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("mrst_o_valid", 32'(bus.o_valid), 32'd0);
      check("mrst_sat_cnt", 32'(bus.o_sat_cnt), 32'd0);
      check("mrst_o_ready", 32'(bus.o_ready), 32'd1);
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_idle", 32'(bus.o_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
